// File: rtl/timing_nco_mu_pkg.sv
// Shared float19 format definitions and interpolator constants for the
// timing-recovery NCO and its fixed-to-float converter.
package timing_nco_mu_pkg;

  localparam int unsigned FLOAT_W  = 19;
  localparam int unsigned SIGN_BIT = 18;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_LSB  = MAN_W;
  localparam int unsigned EXP_BIAS = 127;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float19_t;

  localparam logic [FLOAT_W-1:0] FLOAT_ZERO     = '0;
  // 0.5 and 1.5 as consumed by the Farrow interpolator coefficients
  localparam logic [FLOAT_W-1:0] FLOAT_HALF     = 19'h1F800;
  localparam logic [FLOAT_W-1:0] FLOAT_ONE_HALF = 19'h1FE00;

endpackage

// File: rtl/timing_nco_mu_fx2fp19.sv
// Combinational unsigned fixed-point (v/2^FRAC_W) to float19 converter:
// leading-one detect, exponent from its position, truncated mantissa.
module timing_nco_mu_fx2fp19
  import timing_nco_mu_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int FRAC_W     = 16
) (
  input  logic [FRAC_W-1:0]     x,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int LW = $clog2(FRAC_W);

  logic [LW-1:0] lead;
  logic          nonzero;
  float19_t      f;

  always_comb begin
    lead    = '0;
    nonzero = 1'b0;
    for (int unsigned i = 0; i < FRAC_W; i++) begin
      if (x[i]) begin
        lead    = LW'(i);
        nonzero = 1'b1;
      end
    end
  end

  always_comb begin
    f = '0;
    if (nonzero) begin
      f.sign = 1'b0;
      f.exp  = EXP_W'(EXP_BIAS - FRAC_W) + EXP_W'(lead);
      // Bits below the leading one, MSB-first; positions below bit 0 stay zero
      for (int unsigned i = 0; i < MAN_W; i++) begin
        if (int'(lead) > int'(i))
          f.man[MAN_W-1-i] = x[LW'(int'(lead) - 1 - int'(i))];
      end
    end
  end

  assign y = DATA_WIDTH'(f);

endmodule

// File: rtl/timing_nco_mu.sv
// Timing-recovery NCO: modulo-1 down-counter stepped by W per sample; on
// underflow emits a symbol strobe and the float19 fractional interval mu.
module timing_nco_mu
  import timing_nco_mu_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int FRAC_W     = 16,
  parameter int SPS_LOG2   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [FRAC_W-1:0]     loop_err,
  input  logic                  loop_valid,
  output logic [DATA_WIDTH-1:0] mu,
  output logic                  strobe,
  output logic [FRAC_W-1:0]     w_word
);

  localparam logic [FRAC_W-1:0] W_NOM = FRAC_W'(2 ** (FRAC_W - SPS_LOG2));
  localparam logic [FRAC_W-1:0] W_MIN = W_NOM - (W_NOM >> 2);
  localparam logic [FRAC_W-1:0] W_MAX = W_NOM + (W_NOM >> 2);
  localparam logic signed [FRAC_W+1:0] W_MIN_S = $signed({2'b00, W_MIN});
  localparam logic signed [FRAC_W+1:0] W_MAX_S = $signed({2'b00, W_MAX});

  logic [FRAC_W-1:0]          eta;
  logic [FRAC_W-1:0]          w_reg;
  logic [FRAC_W-1:0]          mu_fix;
  logic                       strobe_s1;

  logic signed [FRAC_W+1:0]   w_sum;
  logic [FRAC_W-1:0]          w_next;
  logic [FRAC_W:0]            diff;
  logic                       borrow;
  logic [2*FRAC_W-1:0]        eta_shift;
  logic [FRAC_W-1:0]          mu_sat;
  logic [DATA_WIDTH-1:0]      mu_fp;

  always_comb begin
    w_sum = $signed({2'b00, W_NOM}) +
            $signed({{2{loop_err[FRAC_W-1]}}, loop_err});
    if (w_sum < W_MIN_S)
      w_next = W_MIN;
    else if (w_sum > W_MAX_S)
      w_next = W_MAX;
    else
      w_next = w_sum[FRAC_W-1:0];
  end

  always_comb begin
    diff      = {1'b0, eta} - {1'b0, w_reg};
    borrow    = diff[FRAC_W];
    eta_shift = {{FRAC_W{1'b0}}, eta} << SPS_LOG2;
    // Any bit shifted past the fraction saturates mu to just below 1.0
    mu_sat    = (|eta_shift[2*FRAC_W-1:FRAC_W]) ? '1 : eta_shift[FRAC_W-1:0];
  end

  timing_nco_mu_fx2fp19 #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_W     (FRAC_W)
  ) u_fx2fp (
    .x (mu_fix),
    .y (mu_fp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eta       <= '0;
      w_reg     <= W_NOM;
      mu_fix    <= '0;
      strobe_s1 <= 1'b0;
      strobe    <= 1'b0;
      mu        <= '0;
    end else begin
      if (loop_valid)
        w_reg <= w_next;
      if (sample_valid) begin
        eta       <= diff[FRAC_W-1:0];
        strobe_s1 <= borrow;
        if (borrow)
          mu_fix <= mu_sat;
      end else begin
        strobe_s1 <= 1'b0;
      end
      strobe <= strobe_s1;
      if (strobe_s1)
        mu <= mu_fp;
    end
  end

  assign w_word = w_reg;

endmodule

// File: tb/tb_timing_nco_mu.sv
// Directed scoreboard bench for timing_nco_mu: the driver pushes expected
// strobe cycle and mu; a negedge monitor pops and compares on each strobe.
module tb_timing_nco_mu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_valid;
  logic [15:0] loop_err;
  logic        loop_valid;
  logic [18:0] mu;
  logic        strobe;
  logic [15:0] w_word;

  typedef struct {
    int unsigned cyc;
    logic [18:0] mu;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_fail = 0;
  logic [18:0] mu_hold = '0;

  timing_nco_mu #(
    .DATA_WIDTH (19),
    .FRAC_W     (16),
    .SPS_LOG2   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .loop_err     (loop_err),
    .loop_valid   (loop_valid),
    .mu           (mu),
    .strobe       (strobe),
    .w_word       (w_word)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Called at posedge+1; inputs are captured at the following posedge
  task automatic step(input logic sv, input logic lv, input logic [15:0] err,
                      input logic exp_str, input logic [18:0] exp_mu);
    exp_t e;
    sample_valid = sv;
    loop_valid   = lv;
    loop_err     = err;
    if (exp_str) begin
      e.cyc = cyc + 2;
      e.mu  = exp_mu;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    loop_valid   = 1'b0;
    loop_err     = '0;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 19'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("strobe_in_reset", {31'b0, strobe}, 32'h0);
      check("mu_in_reset", {13'b0, mu}, 32'h0);
    end else if (strobe) begin
      if (q.size() == 0) begin
        check("unexpected_strobe", {31'b0, strobe}, 32'h0);
      end else begin
        e = q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("mu_on_strobe", {13'b0, mu}, {13'b0, e.mu});
        mu_hold = e.mu;
      end
    end else begin
      check("mu_hold", {13'b0, mu}, {13'b0, mu_hold});
      if (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("missing_strobe_at", cyc, 32'hFFFF_FFFF);
        check("missing_strobe_mu", {13'b0, mu}, {13'b0, e.mu});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    loop_valid   = 1'b0;
    loop_err     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_w", {16'b0, w_word}, 32'h8000);
    check("reset_mu", {13'b0, mu}, 32'h0);
    check("reset_strobe", {31'b0, strobe}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Nominal W: strobe on every second sample, mu stays zero
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 16'h0, 1'b1, 19'h00000);
      step(1'b1, 1'b0, 16'h0, 1'b0, 19'h00000);
    end
    check("w_nominal", {16'b0, w_word}, 32'h8000);
    idle(2);

    // W = 0x9000 from eta = 0
    step(1'b0, 1'b1, 16'h1000, 1'b0, 19'h0);
    check("w_9000", {16'b0, w_word}, 32'h9000);
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h00000); // eta -> 7000
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1FB00); // mu_fix E000 (0.875), eta -> E000
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // eta -> 5000
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1F900); // mu_fix A000, eta -> C000
    idle(2);

    // Clamp limits
    step(1'b0, 1'b1, 16'h4000, 1'b0, 19'h0);
    check("clamp_hi", {16'b0, w_word}, 32'hA000);
    step(1'b0, 1'b1, 16'h8001, 1'b0, 19'h0);
    check("clamp_lo", {16'b0, w_word}, 32'h6000);
    step(1'b0, 1'b1, 16'h2000, 1'b0, 19'h0);
    check("w_at_max", {16'b0, w_word}, 32'hA000);

    // W = 0xA000 from eta = C000
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // eta -> 2000
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1F400); // mu_fix 4000, eta -> 8000
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1FBFF); // 8000<<1 saturates, eta -> E000
    idle(2);

    // Coincident loop update: this decrement still uses A000
    step(1'b1, 1'b1, 16'hE000, 1'b0, 19'h0);  // eta -> 4000, W -> 6000
    check("w_6000", {16'b0, w_word}, 32'h6000);
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1F800); // mu_fix 8000, eta -> E000
    idle(2);

    // Gapped samples with W = 6000
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // eta -> 8000
    idle(1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // eta -> 2000
    idle(1);
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1F400); // mu_fix 4000, eta -> C000
    idle(1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // eta -> 6000
    idle(3);

    // Reset while a borrow is in stage 1
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // eta -> 0
    step(1'b1, 1'b0, 16'h0, 1'b0, 19'h0);     // borrows; strobe must be aborted
    rst_n   = 1'b0;
    mu_hold = '0;
    #1;
    check("async_mu", {13'b0, mu}, 32'h0);
    check("async_strobe", {31'b0, strobe}, 32'h0);
    check("async_w", {16'b0, w_word}, 32'h8000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Post-reset: first sample strobes with mu = 0, then saturation from 9000
    step(1'b0, 1'b1, 16'hF000, 1'b0, 19'h0);
    check("w_7000", {16'b0, w_word}, 32'h7000);
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h00000); // eta -> 9000
    step(1'b0, 1'b1, 16'h2000, 1'b0, 19'h0);
    check("w_a000", {16'b0, w_word}, 32'hA000);
    step(1'b1, 1'b0, 16'h0, 1'b1, 19'h1FBFF); // 9000<<1 saturates to FFFF
    idle(5);

    check("queue_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
